// File: rtl/led_frame_scheduler_if.sv
// led_frame_scheduler_if: requester, trigger, frame RAM write and driver-config signals of the frame scheduler.
interface led_frame_scheduler_if #(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned ADDRESSWIDTH = 6
);
    logic                    a_valid;
    logic [ADDRESSWIDTH-1:0] a_index;
    logic [DATAWIDTH-1:0]    a_data;
    logic                    a_ready;
    logic                    b_valid;
    logic [ADDRESSWIDTH-1:0] b_index;
    logic [DATAWIDTH-1:0]    b_data;
    logic                    b_ready;
    logic                    commit;
    logic                    auto_enable;
    logic [15:0]             num_leds;
    logic                    mem_write_en;
    logic [ADDRESSWIDTH-1:0] mem_write_address;
    logic [DATAWIDTH-1:0]    mem_data_in;
    logic [31:0]             config_out;
    logic                    driver_done;
    logic                    busy;
    logic                    dirty;
    logic [15:0]             frame_count;
    logic                    oob_err;
    logic                    timeout_err;
    modport master (
        output a_valid, a_index, a_data, b_valid, b_index, b_data, commit, auto_enable, num_leds, driver_done,
        input  a_ready, b_ready, mem_write_en, mem_write_address, mem_data_in, config_out, busy, dirty,
               frame_count, oob_err, timeout_err
    );
    modport slave (
        input  a_valid, a_index, a_data, b_valid, b_index, b_data, commit, auto_enable, num_leds, driver_done,
        output a_ready, b_ready, mem_write_en, mem_write_address, mem_data_in, config_out, busy, dirty,
               frame_count, oob_err, timeout_err
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: arbitrates pixel writes into the frame RAM and sequences WS2812 refreshes,
// closing the write window while a frame is armed or shifting out.
module led_frame_scheduler #(
    parameter int unsigned DATAWIDTH     = 32,
    parameter int unsigned ADDRESSWIDTH  = 6,
    parameter int unsigned START_ADDRESS = 12,
    parameter int unsigned MAX_LEDS      = 8,
    parameter int unsigned REFRESH_TICKS = 1666667,
    parameter int unsigned LATCH_TICKS   = 5000,
    parameter int unsigned TIMEOUT_TICKS = 100000
) (
    input logic clk,
    input logic reset_n,
    led_frame_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, SEND, LATCH} state_e;
    state_e                  state_q, state_d;
    logic                    last_b_q;
    logic                    commit_pend_q, tick_pend_q, dirty_q, oob_q, tmo_q, we_q;
    logic [ADDRESSWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0]    data_q;
    logic [15:0]             count_q, frames_q;
    logic [31:0]             period_q, timer_q;
    logic [15:0]             eff_count;
    logic                    win, a_rdy, b_rdy, xfer, in_range, wrap, done, timeout;
    logic [ADDRESSWIDTH-1:0] idx;
    logic [DATAWIDTH-1:0]    wdata;

    always_comb begin
        eff_count = bus.num_leds > 16'(MAX_LEDS) ? 16'(MAX_LEDS) : bus.num_leds;
        win       = state_q == IDLE || state_q == LATCH;
        // last_b_q=1 means B won the last transfer, so A wins a tie
        a_rdy     = win && bus.a_valid && (!bus.b_valid || last_b_q);
        b_rdy     = win && bus.b_valid && (!bus.a_valid || !last_b_q);
        xfer      = a_rdy || b_rdy;
        idx       = b_rdy ? bus.b_index : bus.a_index;
        wdata     = b_rdy ? bus.b_data : bus.a_data;
        in_range  = 16'(idx) < eff_count;
        wrap      = period_q == REFRESH_TICKS - 1;
        done      = state_q == SEND && bus.driver_done;
        timeout   = state_q == SEND && !bus.driver_done && timer_q == TIMEOUT_TICKS - 1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.commit || commit_pend_q || (bus.auto_enable && tick_pend_q)) state_d = ARM;
            ARM:     state_d = eff_count == 16'd0 ? IDLE : SEND;
            SEND:    if (done || timeout) state_d = LATCH;
            LATCH:   if (timer_q == LATCH_TICKS - 1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.a_ready           = a_rdy;
        bus.b_ready           = b_rdy;
        bus.busy              = state_q != IDLE;
        bus.config_out        = {state_q == SEND, 15'd0, count_q};
        bus.mem_write_en      = we_q;
        bus.mem_write_address = addr_q;
        bus.mem_data_in       = data_q;
        bus.dirty             = dirty_q;
        bus.frame_count       = frames_q;
        bus.oob_err           = oob_q;
        bus.timeout_err       = tmo_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_b_q      <= 1'b1;
            commit_pend_q <= 1'b0;
            tick_pend_q   <= 1'b0;
            dirty_q       <= 1'b0;
            oob_q         <= 1'b0;
            tmo_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            count_q       <= '0;
            frames_q      <= '0;
            period_q      <= '0;
            timer_q       <= '0;
        end else begin
            last_b_q      <= xfer ? b_rdy : last_b_q;
            we_q          <= xfer && in_range;
            addr_q        <= ADDRESSWIDTH'(START_ADDRESS) + idx;
            data_q        <= wdata;
            oob_q         <= oob_q || (xfer && !in_range);
            tmo_q         <= tmo_q || timeout;
            frames_q      <= frames_q + 16'(done);
            period_q      <= wrap ? '0 : period_q + 1;
            timer_q       <= (state_d == state_q && state_q != IDLE) ? timer_q + 1 : '0;
            // ARM consumes the triggers; a set in the same cycle still wins
            commit_pend_q <= bus.commit || (commit_pend_q && state_q != ARM);
            tick_pend_q   <= (wrap && bus.auto_enable && dirty_q) || (tick_pend_q && state_q != ARM);
            dirty_q       <= (xfer && in_range) || (dirty_q && state_q != ARM);
            if (state_q == ARM) count_q <= eff_count;
        end
    end
endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler: vector table for arbitration/write path, hand sequences for frames,
// auto-refresh, timeout and reset, plus randomized writes against a behavioural model.
module tb_led_frame_scheduler;
    localparam int unsigned R = 100, L = 40, T = 150;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;

    led_frame_scheduler_if bus();
    led_frame_scheduler #(.REFRESH_TICKS(R), .LATCH_TICKS(L), .TIMEOUT_TICKS(T))
        dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic av; logic [5:0] ai; logic [31:0] ad;
        logic bv; logic [5:0] bi; logic [31:0] bd;
        logic ar; logic br; logic we; logic [5:0] addr; logic [31:0] data;
    } vec_t;
    vec_t vecs[8];

    logic mlast_b, mdirty, moob, exp_a, exp_b, ok, seen;
    logic [5:0] g;
    logic [15:0] eff;
    int n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_index = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_index = '0; bus.b_data = '0;
        bus.commit = 1'b0; bus.auto_enable = 1'b0; bus.num_leds = 16'd8; bus.driver_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_done();
        bus.driver_done = 1'b1;
        tick();
        bus.driver_done = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 6'd3, 32'h00FF0000, 1'b0, 6'd0, 32'h0,  1'b1, 1'b0, 1'b1, 6'd15, 32'h00FF0000};
        vecs[1] = '{1'b1, 6'd1, 32'h11,       1'b1, 6'd2, 32'h22, 1'b0, 1'b1, 1'b1, 6'd14, 32'h22};
        vecs[2] = '{1'b1, 6'd4, 32'h44,       1'b1, 6'd5, 32'h55, 1'b1, 1'b0, 1'b1, 6'd16, 32'h44};
        vecs[3] = '{1'b1, 6'd4, 32'h44,       1'b1, 6'd6, 32'h66, 1'b0, 1'b1, 1'b1, 6'd18, 32'h66};
        vecs[4] = '{1'b1, 6'd7, 32'h77,       1'b1, 6'd6, 32'h66, 1'b1, 1'b0, 1'b1, 6'd19, 32'h77};
        vecs[5] = '{1'b0, 6'd0, 32'h0,        1'b1, 6'd9, 32'h99, 1'b0, 1'b1, 1'b0, 6'd0,  32'h0};
        vecs[6] = '{1'b0, 6'd2, 32'h0,        1'b0, 6'd3, 32'h0,  1'b0, 1'b0, 1'b0, 6'd0,  32'h0};
        vecs[7] = '{1'b1, 6'd0, 32'hABCDEF,   1'b0, 6'd0, 32'h0,  1'b1, 1'b0, 1'b1, 6'd12, 32'hABCDEF};

        idle_inputs();
        tick();
        tick();
        chk("rst busy", bus.busy, 0);
        chk("rst config", bus.config_out, 0);
        chk("rst frames", bus.frame_count, 0);
        chk("rst flags", {bus.dirty, bus.oob_err, bus.timeout_err, bus.mem_write_en}, 0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            bus.a_valid = vecs[i].av; bus.a_index = vecs[i].ai; bus.a_data = vecs[i].ad;
            bus.b_valid = vecs[i].bv; bus.b_index = vecs[i].bi; bus.b_data = vecs[i].bd;
            #1;
            chk($sformatf("vec%0d ready", i), {bus.a_ready, bus.b_ready}, {vecs[i].ar, vecs[i].br});
            tick();
            chk($sformatf("vec%0d we", i), bus.mem_write_en, vecs[i].we);
            if (vecs[i].we) chk($sformatf("vec%0d wr", i), {bus.mem_write_address, bus.mem_data_in}, {vecs[i].addr, vecs[i].data});
        end
        idle_inputs();
        chk("vec dirty", bus.dirty, 1);
        chk("vec oob", bus.oob_err, 1);

        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        chk("arm busy", bus.busy, 1);
        chk("arm no start", bus.config_out, 0);
        tick();
        chk("send config", bus.config_out, 32'h80000008);
        chk("send dirty cleared", bus.dirty, 0);
        bus.a_valid = 1'b1; bus.a_index = 6'd5; bus.a_data = 32'h00123456;
        #1;
        chk("send a_ready", bus.a_ready, 0);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        repeat (3) tick();
        chk("send a_ready held", bus.a_ready, 0);
        pulse_done();
        chk("latch start bit", bus.config_out[31], 0);
        chk("frame 1", bus.frame_count, 1);
        chk("latch busy", bus.busy, 1);
        chk("latch a_ready", bus.a_ready, 1);
        tick();
        bus.a_valid = 1'b0;
        chk("latch write", {bus.mem_write_en, bus.mem_write_address, bus.mem_data_in}, {1'b1, 6'd17, 32'h00123456});
        n = 1;
        while (!bus.config_out[31] && n < 3 * L) begin tick(); n++; end
        chk("second frame delay", n, L + 2);
        chk("second frame config", bus.config_out, 32'h80000008);
        pulse_done();
        chk("frame 2", bus.frame_count, 2);
        repeat (L - 1) tick();
        chk("latch end-1 busy", bus.busy, 1);
        tick();
        chk("idle after latch", bus.busy, 0);
        pulse_done();
        chk("done in idle ignored", bus.frame_count, 2);

        bus.auto_enable = 1'b1;
        seen = 1'b0;
        repeat (2 * R + 5) begin tick(); if (bus.busy) seen = 1'b1; end
        chk("auto clean no start", seen, 0);
        bus.a_valid = 1'b1; bus.a_index = 6'd2;
        tick();
        bus.a_valid = 1'b0;
        n = 0;
        while (!bus.busy && n < R + 5) begin tick(); n++; end
        chk("auto dirty start", bus.busy, 1);
        tick();
        chk("auto config", bus.config_out, 32'h80000008);
        bus.auto_enable = 1'b0;
        pulse_done();
        repeat (L + 2) tick();
        chk("auto frame done", {bus.busy, bus.frame_count}, {1'b0, 16'd3});

        do_reset();
        bus.num_leds = 16'd20;
        bus.a_valid = 1'b1; bus.a_index = 6'd9; bus.a_data = 32'h5;
        #1;
        chk("oob ready", bus.a_ready, 1);
        tick();
        bus.a_valid = 1'b0;
        chk("oob no write", bus.mem_write_en, 0);
        chk("oob flags", {bus.oob_err, bus.dirty}, 2'b10);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        tick();
        chk("clamp config", bus.config_out, 32'h80000008);
        repeat (T - 1) tick();
        chk("pre-timeout", {bus.config_out[31], bus.timeout_err}, 2'b10);
        tick();
        chk("timeout", {bus.config_out[31], bus.timeout_err, bus.busy}, 3'b011);
        chk("timeout frames", bus.frame_count, 0);
        repeat (L) tick();
        chk("timeout latch end", bus.busy, 0);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        repeat (4) tick();
        chk("resend", bus.config_out[31], 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst config", bus.config_out, 0);
        chk("async rst outs", {bus.busy, bus.timeout_err, bus.oob_err, bus.dirty, bus.frame_count}, 0);
        tick();
        reset_n = 1'b1;
        idle_inputs();
        tick();

        mlast_b = 1'b1; mdirty = 1'b0; moob = 1'b0;
        for (int i = 0; i < 150; i++) begin
            bus.a_valid = 1'($urandom_range(0, 1)); bus.a_index = 6'($urandom_range(0, 15)); bus.a_data = $urandom;
            bus.b_valid = 1'($urandom_range(0, 1)); bus.b_index = 6'($urandom_range(0, 15)); bus.b_data = $urandom;
            bus.num_leds = 16'($urandom_range(0, 12));
            #1;
            exp_a = bus.a_valid && (!bus.b_valid || mlast_b);
            exp_b = bus.b_valid && (!bus.a_valid || !mlast_b);
            chk("rnd ready", {bus.a_ready, bus.b_ready}, {exp_a, exp_b});
            g = exp_b ? bus.b_index : bus.a_index;
            eff = bus.num_leds > 16'd8 ? 16'd8 : bus.num_leds;
            ok = (exp_a || exp_b) && 16'(g) < eff;
            if (exp_a || exp_b) begin
                mlast_b = exp_b;
                moob = moob | !ok;
            end
            mdirty = mdirty | ok;
            tick();
            chk("rnd we", bus.mem_write_en, ok);
            if (ok) chk("rnd write", {bus.mem_write_address, bus.mem_data_in},
                        {6'(g + 6'd12), exp_b ? bus.b_data : bus.a_data});
        end
        idle_inputs();
        chk("rnd flags", {bus.dirty, bus.oob_err}, {mdirty, moob});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
Sequences the WS2812 LED driver and owns the write port of its frame RAM. Round-robin arbitrates pixel writes from two requesters (host and pattern generator) into the RAM. Issues refresh starts via the driver config word, either on explicit commit or on a periodic tick. Blocks writes while a frame is being shifted out, so frames never tear.

Parameters:
DATAWIDTH, 32, pixel word width (GRB in [23:0])
ADDRESSWIDTH, 6, frame RAM word address width
START_ADDRESS, 12, RAM word address of LED 0
MAX_LEDS, 8, upper clamp for num_leds
REFRESH_TICKS, 1666667, auto-refresh period in clk cycles (60 Hz at 100 MHz)
LATCH_TICKS, 5000, post-frame hold-off in cycles (50 us WS2812 latch)
TIMEOUT_TICKS, 100000, maximum SEND duration before abort

Ports:
clk  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous, active-low reset
a_valid  in  1  host write request
a_index  in  ADDRESSWIDTH  host LED index
a_data  in  DATAWIDTH  host pixel
a_ready  out  1  host write accepted this cycle
b_valid, b_index, b_data, b_ready  as a_*  pattern-generator requester
commit  in  1  pulse: refresh as soon as possible
auto_enable  in  1  enable periodic refresh
num_leds  in  16  LED count for the next frame
mem_write_en  out  1  frame RAM write enable
mem_write_address  out  ADDRESSWIDTH  frame RAM write address
mem_data_in  out  DATAWIDTH  frame RAM write data
config_out  out  32  driver config: [31] start/run, [15:0] LED count, others 0
driver_done  in  1  pulse from driver: frame fully shifted
busy  out  1  state != IDLE
dirty  out  1  in-range write accepted since last frame start
frame_count  out  16  completed frames, wraps at 0xFFFF->0
oob_err  out  1  sticky: write with index >= effective count
timeout_err  out  1  sticky: SEND exceeded TIMEOUT_TICKS

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Pending flags, counters and sticky errors cleared. last_grant=B, so A wins the first tie. Reset mid-SEND drops config_out[31] immediately.
- eff_count = min(num_leds, MAX_LEDS).
- FSM states:
  - IDLE: if commit_pending or (auto_enable and tick_pending), go to ARM.
  - ARM (1 cycle): latch eff_count into config_out[15:0]; clear dirty, commit_pending and tick_pending. If eff_count==0, go to IDLE with no start and no frame_count increment. Otherwise go to SEND.
  - SEND: config_out[31]=1. On driver_done: frame_count+1, config_out[31]=0 at the next edge, go to LATCH. On timeout counter reaching TIMEOUT_TICKS: set timeout_err, config_out[31]=0, go to LATCH.
  - LATCH: count LATCH_TICKS cycles, then go to IDLE.
- Latency: commit sampled at edge N in IDLE gives ARM after N, and config_out[31]=1 after N+1.
- commit_pending is set by commit in any state, including SEND. A commit during SEND yields exactly one extra frame after LATCH. Multiple commits before ARM collapse into one.
- Period counter runs freely mod REFRESH_TICKS. On wrap it sets tick_pending only if auto_enable and dirty, so unchanged frames are not resent.
- Write window is open in IDLE and LATCH only. In ARM and SEND, a_ready=b_ready=0.
- Arbitration (combinational ready):
  - Only one requester valid: it gets ready.
  - Both valid: the one not equal to last_grant gets ready; last_grant updates on each transfer.
  - At most one ready per cycle.
- Write path (registered): a transfer at edge N drives mem_write_en=1 with address START_ADDRESS+index (mod 2^ADDRESSWIDTH) and data at N+1, for one cycle.
  - Index >= eff_count: transfer is acknowledged, no RAM write, oob_err set, dirty unchanged.
- A write accepted in the same IDLE cycle a trigger is seen lands in RAM during ARM and is included in that frame.
- driver_done outside SEND is ignored.

Test Plan:
- Reset then a_valid, index 3, data 0x00FF0000 -> a_ready=1; next cycle mem_write_en=1, address 15, data 0x00FF0000; dirty=1.
- a_valid and b_valid held 4 cycles -> grants alternate A,B,A,B; exactly 4 RAM writes.
- num_leds=8, commit pulse at cycle 10 -> config_out=0x80000008 from cycle 12. driver_done at 100 -> config_out[31]=0 at 101, frame_count=1, busy low 5000 cycles later.
- During SEND, a_valid held and commit pulsed -> a_ready=0 until LATCH. Host write accepted in LATCH; second frame starts after LATCH; frame_count=2.
- auto_enable=1, REFRESH_TICKS=100, no writes -> no start. One write -> start after next wrap. num_leds=20 -> config_out[15:0]=8; index 9 write sets oob_err with no RAM write.
- SEND with no driver_done for TIMEOUT_TICKS -> timeout_err=1, config_out[31]=0, frame_count unchanged. reset_n low mid-SEND -> all outputs 0 immediately.
